// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// mul_ctrl : sequencer wrapping a fixed-latency unsigned 32x32 multiplier
//            (sign handling, launch, result capture, response handshake)
// Revision   : 1.0
// ============================================================================
module mul_ctrl #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_tag,
  input  logic        flush,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_start,
  input  logic [63:0] dp_product,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_tag
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [3:0] LAT       = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic        neg;
  logic        accept;
  logic        finish;
  logic        rs1_signed;
  logic        rs2_signed;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        neg_nxt;
  logic [63:0] prod_fix;
  logic [31:0] sel_word;

  // The datapath is unsigned; operands go in as magnitudes and the sign is
  // reapplied to the full 64-bit product on capture.
  always_comb begin
    rs1_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU);
    rs2_signed = (req_op == OP_MULH);
    mag1       = (rs1_signed && req_rs1[31]) ? (32'd0 - req_rs1) : req_rs1;
    mag2       = (rs2_signed && req_rs2[31]) ? (32'd0 - req_rs2) : req_rs2;
    neg_nxt    = (rs1_signed & req_rs1[31]) ^ (rs2_signed & req_rs2[31]);
  end

  assign req_ready  = (state == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign dp_start   = (state == BUSY) && (cnt == 4'd0);
  assign resp_valid = (state == DONE);
  assign finish     = (state == BUSY) && !flush && (cnt == LAT);
  assign prod_fix   = neg ? (64'd0 - dp_product) : dp_product;
  assign sel_word   = (op == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: begin
        if (flush)           state_nxt = IDLE;
        else if (cnt == LAT) state_nxt = DONE;
      end
      DONE: if (flush || resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op        <= 2'd0;
      neg       <= 1'b0;
      dp_a      <= 32'd0;
      dp_b      <= 32'd0;
      resp_data <= 32'd0;
      resp_tag  <= 5'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= 4'd0;
        op       <= req_op;
        neg      <= neg_nxt;
        dp_a     <= mag1;
        dp_b     <= mag2;
        resp_tag <= req_tag;
      end else if (state == BUSY) begin
        cnt <= cnt + 4'd1;
      end
      if (finish) resp_data <= sel_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// tb_mul_ctrl : directed vectors against a transaction-level model of the
// controller, with an emulated fixed-latency multiplier datapath.
module tb_mul_ctrl;

  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, flush, dp_start, resp_valid, resp_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2, dp_a, dp_b, resp_data;
  logic [4:0]  req_tag, resp_tag;
  logic [63:0] dp_product;

  mul_ctrl #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .dp_a(dp_a), .dp_b(dp_b), .dp_start(dp_start), .dp_product(dp_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Multiplier datapath: product appears LATENCY cycles after dp_start, junk otherwise.
  logic [63:0] pipe_p [LATENCY];
  logic        pipe_v [LATENCY];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_p[i] <= 64'd0;
      end
    end else begin
      pipe_v[0] <= dp_start;
      pipe_p[0] <= 64'(dp_a) * 64'(dp_b);
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end
  assign dp_product = pipe_v[LATENCY-1] ? pipe_p[LATENCY-1] : 64'hBAD0_BAD0_BAD0_BAD0;

  // Reference model: cycles elapsed since acceptance (-1 when nothing in flight).
  int          since = -1;
  int          n_acc = 0;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0;
  logic [4:0]  m_tag = '0;

  function automatic logic [31:0] mag(input logic [31:0] v, input bit s);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye, full;
    xe   = (op == 2'b01 || op == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
    ye   = (op == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
    full = xe * ye;
    return (op == 2'b00) ? full[31:0] : full[63:32];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      since <= -1;
      m_a <= '0; m_b <= '0; m_data <= '0; m_tag <= '0;
    end else if (since < 0) begin
      if (req_valid && !flush) begin
        since  <= 1;
        m_a    <= mag(req_rs1, req_op == 2'b01 || req_op == 2'b10);
        m_b    <= mag(req_rs2, req_op == 2'b01);
        m_data <= ref_word(req_op, req_rs1, req_rs2);
        m_tag  <= req_tag;
        n_acc  <= n_acc + 1;
      end
    end else if (flush) begin
      since <= -1;
    end else if (since >= LATENCY + 2) begin
      if (resp_ready) since <= -1;
    end else begin
      since <= since + 1;
    end
  end

  bit run_chk = 1'b0;
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("req_ready",  64'(req_ready),  64'(since < 0 && !flush));
      chk("dp_start",   64'(dp_start),   64'(since == 1));
      chk("resp_valid", 64'(resp_valid), 64'(since >= LATENCY + 2));
      chk("dp_a", 64'(dp_a), 64'(m_a));
      chk("dp_b", 64'(dp_b), 64'(m_b));
      if (since >= LATENCY + 2) begin
        chk("resp_data", 64'(resp_data), 64'(m_data));
        chk("resp_tag",  64'(resp_tag),  64'(m_tag));
      end
    end
  end

  // Present a request and wait for the model to accept it; returns edges waited.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, output int waited);
    int start;
    start     = n_acc;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    req_valid = 1'b1;
    waited    = 0;
    while (n_acc == start && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    req_valid = 1'b0;
    chk("accepted", 64'(n_acc - start), 64'd1);
  endtask

  // Called in the first BUSY cycle; waits for the response, holding resp_ready low for 'hold' DONE cycles.
  task automatic recv(input logic [31:0] lit, input logic [4:0] tag, input bit use_lit, input int hold);
    int cyc, starts;
    bit got;
    cyc = 0; starts = 0; got = 1'b0;
    resp_ready = (hold == 0);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dp_start === 1'b1) starts++;
      if (resp_valid === 1'b1) got = 1'b1;
    end
    chk("resp_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc), 64'(LATENCY + 2));
    chk("dp_start_pulses", 64'(starts), 64'd1);
    chk("tag_lit", 64'(resp_tag), 64'(tag));
    if (use_lit) chk("data_lit", 64'(resp_data), 64'(lit));
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_tag", 64'(resp_tag), 64'(tag));
      if (use_lit) chk("hold_data", 64'(resp_data), 64'(lit));
    end
    @(posedge clk); #1;
    if (hold > 0) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  logic [1:0]  v_op  [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
  logic [31:0] v_a   [6] = '{32'hFFFF_FFFD, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
  logic [31:0] v_b   [6] = '{32'h0000_0005, 32'h9ABC_DEF0, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
  logic [31:0] v_exp [6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
  bit          v_lit [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    req_valid = 0; req_op = 0; req_rs1 = 0; req_rs2 = 0; req_tag = 0;
    flush = 0; resp_ready = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dp_start", 64'(dp_start), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_tag", 64'(resp_tag), 64'd0);
    chk("rst_dp_a", 64'(dp_a), 64'd0);
    chk("rst_dp_b", 64'(dp_b), 64'd0);
    rst = 1'b0;
    run_chk = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // MUL, unsigned low word
    send(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3, w);
    recv(32'hFFFF_FFEB, 5'd3, 1'b1, 0);

    // MULH most-negative squared
    send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd9, w);
    chk("mulh_dp_a", 64'(dp_a), 64'h8000_0000);
    chk("mulh_dp_b", 64'(dp_b), 64'h8000_0000);
    recv(32'h4000_0000, 5'd9, 1'b1, 0);

    // MULHSU vs MULHU on all-ones
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, w);
    chk("mulhsu_dp_a", 64'(dp_a), 64'd1);
    chk("mulhsu_dp_b", 64'(dp_b), 64'hFFFF_FFFF);
    recv(32'hFFFF_FFFF, 5'd17, 1'b1, 0);
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, w);
    recv(32'hFFFF_FFFE, 5'd18, 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      send(v_op[i], v_a[i], v_b[i], 5'(i + 20), w);
      recv(v_exp[i], 5'(i + 20), v_lit[i], 0);
    end

    // Response back-pressure with a request waiting behind it
    send(2'b00, 32'd5, 32'd6, 5'd7, w);
    req_op = 2'b11; req_rs1 = 32'h0001_0000; req_rs2 = 32'h0001_0000; req_tag = 5'd8;
    req_valid = 1'b1;
    recv(32'd30, 5'd7, 1'b1, 4);
    send(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd8, w);
    chk("accept_after_hs", 64'(w), 64'd1);
    recv(32'd1, 5'd8, 1'b1, 0);

    // Flush in IDLE blocks a request
    flush = 1'b1;
    req_op = 2'b00; req_rs1 = 32'd2; req_rs2 = 32'd3; req_tag = 5'd1;
    req_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b0;
    send(2'b00, 32'd2, 32'd3, 5'd1, w);
    chk("accept_after_idle_flush", 64'(w), 64'd1);
    recv(32'd6, 5'd1, 1'b1, 0);

    // Flush in the second BUSY cycle
    send(2'b10, 32'hFFFF_FFF0, 32'd3, 5'd4, w);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    send(2'b01, 32'hFFFF_FFFD, 32'd5, 5'd5, w);
    chk("accept_after_flush", 64'(w), 64'd1);
    recv(32'hFFFF_FFFF, 5'd5, 1'b1, 0);

    // Asynchronous reset in the middle of BUSY
    send(2'b00, 32'd11, 32'd13, 5'd6, w);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_dp_start", 64'(dp_start), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_resp_data", 64'(resp_data), 64'd0);
    chk("arst_resp_tag", 64'(resp_tag), 64'd0);
    chk("arst_dp_a", 64'(dp_a), 64'd0);
    chk("arst_dp_b", 64'(dp_b), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_arst", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    send(2'b11, 32'd3, 32'd5, 5'd10, w);
    recv(32'd0, 5'd10, 1'b1, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
